buf_executor_seq: RTL and testbench
===================================

# buf_executor_seq

Second-generation command-buffer executor: replays 40-bit instructions from an internal dual-port buffer. Each instruction drives the register-write bus, the strobe lines or the interrupt-clear lines, or waits on pending interrupts. Adds over the first generation: a parametrised buffer depth, counted loops, unconditional jump, and per-wait timeouts that abort the program. Sits between the host loader (buffer write port, start/abort) and the motion/peripheral register bus.

## Interface
- BUFFER_ADDR_LEN, 13, buffer depth = 2^BUFFER_ADDR_LEN words of 40 bits; buffer index = pc[BUFFER_ADDR_LEN-1:0]
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ext_out_reg_addr  out  6  register address, valid with stb
- ext_out_reg_data  out  32  register data, valid with stb
- ext_out_reg_stb  out  1  one-cycle register-write strobe
- ext_out_reg_busy  in  1  bus busy; a WRITE_REG stalls while this is high
- ext_out_stbs  out  32  one-cycle strobe vector
- ext_pending_ints  in  32  pending interrupt flags
- ext_clear_ints  out  32  one-cycle interrupt-clear vector
- ext_buffer_addr / ext_buffer_data / ext_buffer_wr  in  16/40/1  buffer write port, usable at any time
- start  in  1  begin execution at start_addr; honoured only when idle
- start_addr  in  16  initial pc
- abort  in  1  stop execution immediately
- complete  out  1  one-cycle pulse when the program ends (DONE or any error)
- pc  out  16  program counter
- error  out  8  status/error code
- busy  out  1  executor running
- waiting  out  1  blocked in WAIT_ALL/WAIT_ANY

## Operation
- States:
  - S_INIT (idle)
  - S_FETCH (buffer read issued)
  - S_DECODE (execute)
- Buffer read is synchronous (1 cycle), so every instruction occupies FETCH followed by ≥1 DECODE cycle.
- Decoding: op = [39:38], sub = [37:32], arg = [31:0].
- op 01 WRITE_REG:
  - If ext_out_reg_busy is low: reg_addr = sub, reg_data = arg, stb = 1, then pc+1.
  - Otherwise stay in DECODE.
- op 10 misc, selected by sub:
  - 0 NOP.
  - 1 STB: ext_out_stbs = arg.
  - 2 WAIT_ALL: proceed when (ints & arg) == arg.
  - 3 WAIT_ANY: proceed when (ints & arg) != 0.
  - 4 CLEAR: ext_clear_ints = arg.
  - 5 LOOP_START: loop_addr = pc+1, loop_cnt = arg[15:0] (a count of 0 is treated as 1), loop_active = 1. Error 0x84 if a loop is already active.
  - 6 LOOP_END:
    - Error 0x85 if no loop is active.
    - If loop_cnt > 1: loop_cnt−1 and pc = loop_addr.
    - Otherwise loop_active = 0 and pc+1.
  - 7 JUMP: pc = arg[15:0].
  - 8 SET_TIMEOUT: timeout = arg; 0 means infinite.
  - 63 DONE: error = arg[7:0], complete = 1, go to S_INIT.
  - Any other sub: error 0x81.
- op 00 / 11: error 0x81.
- Any error: complete = 1, go to S_INIT, error holds the code until the next accepted start.
- Wait timeout: the wait condition is checked once per DECODE cycle, k = 1, 2, …
  - Condition met on check k: proceed.
  - Condition unmet on check k with timeout ≠ 0 and k == timeout: error 0x83 and complete.
  - While unmet and not failing: waiting = 1 and error = 0x02 (next cycle).
  - A WRITE_REG stall is never subject to the timeout.
- Start: pc = start_addr, error = 0, timeout = 0, loop_active = 0, go to S_FETCH.
- pc arithmetic is 16-bit and wraps from 0xFFFF to 0. The buffer index uses only the low BUFFER_ADDR_LEN bits.

## Timing
- Registered outputs: pc, error, busy, waiting.
- Combinational outputs, driven during the DECODE cycle only: ext_out_reg_*, ext_out_stbs, ext_clear_ints, complete.
- Reset values:
  - pc, error, busy, waiting, timeout, loop_cnt, loop_active = 0; state = S_INIT.
  - Every combinational output is 0 while rst is high.
- Priority: rst > abort > start/normal.
- abort: pc = 0, error = 0x82, busy = 0, loop/timeout state cleared. complete is not asserted.
- Latency:
  - start → first FETCH on the next cycle.
  - Each non-stalled instruction takes 2 cycles.
  - busy rises the cycle after start is accepted and falls the cycle after complete.
- Buffer collision: a write to the address being fetched in the same cycle returns the old data (read-before-write).
- start while busy is ignored.
- When the wait condition is met on the same check as the timeout, the instruction proceeds without error.
- An unknown state recovers to S_INIT with error = 0 and busy = 0.

## Test plan
- Program: WRITE_REG(5, 0x1234), STB(0x3), DONE(0x00) at address 0; start with start_addr = 0.
  - stb asserted with addr 5 / data 0x1234 two cycles after start.
  - ext_out_stbs = 0x3 two cycles later.
  - complete pulses, error = 0, busy low the following cycle.
- LOOP_START(3), CLEAR(0x1), LOOP_END, DONE: exactly 3 ext_clear_ints = 0x1 pulses, then complete.
- Variant with LOOP_START(0): exactly 1 pulse.
- SET_TIMEOUT(4), WAIT_ALL(0x6) with ints = 0x2: waiting = 1 and error = 0x02 during the wait, then error 0x83 with complete on the 4th check.
  - Repeat with ints = 0x6 raised on the 4th check: proceeds, no error.
- WRITE_REG with ext_out_reg_busy held high for 10 cycles:
  - No stb, pc unchanged, no timeout even with timeout = 1.
  - stb in the first cycle after busy drops.
- Error cases:
  - Opcode 00 → error 0x81 + complete.
  - Nested LOOP_START → 0x84.
  - Stray LOOP_END → 0x85.
  - JUMP(0xFFFF) followed by NOP at buffer[2^N−1], then DONE at buffer[0]: pc wraps from 0xFFFF to 0 after the NOP, and the program completes.
- abort during a WAIT → error 0x82, pc = 0, busy = 0, no complete.
  - rst asserted together with abort → error 0.
  - start while busy is ignored.

Source files
------------

// File: rtl/buf_executor_seq.sv
`default_nettype none
// ============================================================================
// Module  : buf_executor_seq
// Brief   : Replays 40-bit instructions from an internal dual-port buffer.
//           Supports register writes, strobes, waits with timeout, loops, jumps.
// Revision: 1.0
// ============================================================================
module buf_executor_seq #(
  parameter int BUFFER_ADDR_LEN = 13
) (
  input  logic        clk,
  input  logic        rst,
  output logic [5:0]  ext_out_reg_addr,
  output logic [31:0] ext_out_reg_data,
  output logic        ext_out_reg_stb,
  input  logic        ext_out_reg_busy,
  output logic [31:0] ext_out_stbs,
  input  logic [31:0] ext_pending_ints,
  output logic [31:0] ext_clear_ints,
  input  logic [15:0] ext_buffer_addr,
  input  logic [39:0] ext_buffer_data,
  input  logic        ext_buffer_wr,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic        abort,
  output logic        complete,
  output logic [15:0] pc,
  output logic [7:0]  error,
  output logic        busy,
  output logic        waiting
);

  localparam logic [1:0] C_OP_WRITE       = 2'b01;
  localparam logic [1:0] C_OP_MISC        = 2'b10;
  localparam logic [5:0] C_SUB_NOP        = 6'd0;
  localparam logic [5:0] C_SUB_STB        = 6'd1;
  localparam logic [5:0] C_SUB_WAIT_ALL   = 6'd2;
  localparam logic [5:0] C_SUB_WAIT_ANY   = 6'd3;
  localparam logic [5:0] C_SUB_CLEAR      = 6'd4;
  localparam logic [5:0] C_SUB_LOOP_START = 6'd5;
  localparam logic [5:0] C_SUB_LOOP_END   = 6'd6;
  localparam logic [5:0] C_SUB_JUMP       = 6'd7;
  localparam logic [5:0] C_SUB_TIMEOUT    = 6'd8;
  localparam logic [5:0] C_SUB_DONE       = 6'd63;
  localparam logic [7:0] C_ERR_WAIT       = 8'h02;
  localparam logic [7:0] C_ERR_ILLEGAL    = 8'h81;
  localparam logic [7:0] C_ERR_ABORT      = 8'h82;
  localparam logic [7:0] C_ERR_TIMEOUT    = 8'h83;
  localparam logic [7:0] C_ERR_NESTED     = 8'h84;
  localparam logic [7:0] C_ERR_NO_LOOP    = 8'h85;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [39:0] r_mem [0:(2**BUFFER_ADDR_LEN)-1];
  logic [39:0] r_instr;
  logic [15:0] r_pc, w_pc_next;
  logic [7:0]  r_error, w_error_next;
  logic        r_busy, w_busy_next;
  logic        r_waiting, w_waiting_next;
  logic [31:0] r_timeout, w_timeout_next;
  logic [15:0] r_loop_cnt, w_loop_cnt_next;
  logic [15:0] r_loop_addr, w_loop_addr_next;
  logic        r_loop_active, w_loop_active_next;
  logic [31:0] r_wait_cnt, w_wait_cnt_next;
  logic        w_proceed, w_fail;
  logic [7:0]  w_fail_code;

  wire  [1:0]  w_op      = r_instr[39:38];
  wire  [5:0]  w_sub     = r_instr[37:32];
  wire  [31:0] w_arg     = r_instr[31:0];
  wire  [31:0] w_masked  = ext_pending_ints & w_arg;
  wire         w_wait_met = (w_sub == C_SUB_WAIT_ALL) ? (w_masked == w_arg) : (w_masked != 32'd0);
  wire  [31:0] w_wait_k  = r_wait_cnt + 32'd1;

  generate
    if (BUFFER_ADDR_LEN < 16) begin : g_unused_addr
      wire w_unused_addr = ^{ext_buffer_addr[15:BUFFER_ADDR_LEN], r_pc[15:BUFFER_ADDR_LEN]};
    end
  endgenerate

  // Read and write share one edge, so a same-address write returns old data.
  always_ff @(posedge clk) begin
    if (ext_buffer_wr)
      r_mem[ext_buffer_addr[BUFFER_ADDR_LEN-1:0]] <= ext_buffer_data;
    if (r_state == S_FETCH)
      r_instr <= r_mem[r_pc[BUFFER_ADDR_LEN-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_INIT;
      r_pc          <= 16'd0;
      r_error       <= 8'd0;
      r_busy        <= 1'b0;
      r_waiting     <= 1'b0;
      r_timeout     <= 32'd0;
      r_loop_cnt    <= 16'd0;
      r_loop_addr   <= 16'd0;
      r_loop_active <= 1'b0;
      r_wait_cnt    <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_error       <= w_error_next;
      r_busy        <= w_busy_next;
      r_waiting     <= w_waiting_next;
      r_timeout     <= w_timeout_next;
      r_loop_cnt    <= w_loop_cnt_next;
      r_loop_addr   <= w_loop_addr_next;
      r_loop_active <= w_loop_active_next;
      r_wait_cnt    <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_error_next       = r_error;
    w_busy_next        = r_busy;
    w_waiting_next     = r_waiting;
    w_timeout_next     = r_timeout;
    w_loop_cnt_next    = r_loop_cnt;
    w_loop_addr_next   = r_loop_addr;
    w_loop_active_next = r_loop_active;
    w_wait_cnt_next    = r_wait_cnt;
    ext_out_reg_addr   = 6'd0;
    ext_out_reg_data   = 32'd0;
    ext_out_reg_stb    = 1'b0;
    ext_out_stbs       = 32'd0;
    ext_clear_ints     = 32'd0;
    complete           = 1'b0;
    w_proceed          = 1'b0;
    w_fail             = 1'b0;
    w_fail_code        = 8'd0;
    if (!rst) begin
      if (abort) begin
        w_state_next       = S_INIT;
        w_pc_next          = 16'd0;
        w_error_next       = C_ERR_ABORT;
        w_busy_next        = 1'b0;
        w_waiting_next     = 1'b0;
        w_timeout_next     = 32'd0;
        w_loop_cnt_next    = 16'd0;
        w_loop_addr_next   = 16'd0;
        w_loop_active_next = 1'b0;
        w_wait_cnt_next    = 32'd0;
      end else begin
        case (r_state)
          S_INIT: begin
            if (start) begin
              w_state_next       = S_FETCH;
              w_pc_next          = start_addr;
              w_error_next       = 8'd0;
              w_busy_next        = 1'b1;
              w_waiting_next     = 1'b0;
              w_timeout_next     = 32'd0;
              w_loop_cnt_next    = 16'd0;
              w_loop_active_next = 1'b0;
              w_wait_cnt_next    = 32'd0;
            end
          end
          S_FETCH: w_state_next = S_DECODE;
          S_DECODE: begin
            if (w_op == C_OP_WRITE) begin
              if (!ext_out_reg_busy) begin
                ext_out_reg_addr = w_sub;
                ext_out_reg_data = w_arg;
                ext_out_reg_stb  = 1'b1;
                w_proceed        = 1'b1;
              end
            end else if (w_op == C_OP_MISC) begin
              case (w_sub)
                C_SUB_NOP: w_proceed = 1'b1;
                C_SUB_STB: begin
                  ext_out_stbs = w_arg;
                  w_proceed    = 1'b1;
                end
                C_SUB_WAIT_ALL, C_SUB_WAIT_ANY: begin
                  // Met on the final permitted check still wins over the timeout.
                  if (w_wait_met) begin
                    w_proceed    = 1'b1;
                    w_error_next = 8'd0;
                  end else if (r_timeout != 32'd0 && w_wait_k == r_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = C_ERR_TIMEOUT;
                  end else begin
                    w_waiting_next  = 1'b1;
                    w_error_next    = C_ERR_WAIT;
                    w_wait_cnt_next = w_wait_k;
                  end
                end
                C_SUB_CLEAR: begin
                  ext_clear_ints = w_arg;
                  w_proceed      = 1'b1;
                end
                C_SUB_LOOP_START: begin
                  if (r_loop_active) begin
                    w_fail      = 1'b1;
                    w_fail_code = C_ERR_NESTED;
                  end else begin
                    w_loop_addr_next   = r_pc + 16'd1;
                    w_loop_cnt_next    = (w_arg[15:0] == 16'd0) ? 16'd1 : w_arg[15:0];
                    w_loop_active_next = 1'b1;
                    w_proceed          = 1'b1;
                  end
                end
                C_SUB_LOOP_END: begin
                  if (!r_loop_active) begin
                    w_fail      = 1'b1;
                    w_fail_code = C_ERR_NO_LOOP;
                  end else if (r_loop_cnt > 16'd1) begin
                    w_loop_cnt_next = r_loop_cnt - 16'd1;
                    w_pc_next       = r_loop_addr;
                    w_state_next    = S_FETCH;
                  end else begin
                    w_loop_active_next = 1'b0;
                    w_proceed          = 1'b1;
                  end
                end
                C_SUB_JUMP: begin
                  w_pc_next    = w_arg[15:0];
                  w_state_next = S_FETCH;
                end
                C_SUB_TIMEOUT: begin
                  w_timeout_next = w_arg;
                  w_proceed      = 1'b1;
                end
                C_SUB_DONE: begin
                  w_error_next    = w_arg[7:0];
                  complete        = 1'b1;
                  w_state_next    = S_INIT;
                  w_busy_next     = 1'b0;
                  w_waiting_next  = 1'b0;
                  w_wait_cnt_next = 32'd0;
                end
                default: begin
                  w_fail      = 1'b1;
                  w_fail_code = C_ERR_ILLEGAL;
                end
              endcase
            end else begin
              w_fail      = 1'b1;
              w_fail_code = C_ERR_ILLEGAL;
            end
            if (w_proceed) begin
              w_pc_next       = r_pc + 16'd1;
              w_state_next    = S_FETCH;
              w_waiting_next  = 1'b0;
              w_wait_cnt_next = 32'd0;
            end
            if (w_fail) begin
              w_error_next    = w_fail_code;
              complete        = 1'b1;
              w_state_next    = S_INIT;
              w_busy_next     = 1'b0;
              w_waiting_next  = 1'b0;
              w_wait_cnt_next = 32'd0;
            end
          end
          default: begin
            w_state_next   = S_INIT;
            w_error_next   = 8'd0;
            w_busy_next    = 1'b0;
            w_waiting_next = 1'b0;
          end
        endcase
      end
    end
  end

  assign pc      = r_pc;
  assign error   = r_error;
  assign busy    = r_busy;
  assign waiting = r_waiting;

endmodule
`default_nettype wire

// File: tb/tb_buf_executor_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_buf_executor_seq
// Brief   : Scoreboard bench for buf_executor_seq with directed programs.
// Revision: 1.0
// ============================================================================
module tb_buf_executor_seq;

  localparam logic [1:0]  K_REG  = 2'd0;
  localparam logic [1:0]  K_STB  = 2'd1;
  localparam logic [1:0]  K_CLR  = 2'd2;
  localparam logic [1:0]  K_DONE = 2'd3;
  localparam logic [31:0] NOCYC  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [1:0]  kind;
    logic [39:0] val;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, abort, start, ext_out_reg_busy, ext_buffer_wr;
  logic [15:0] start_addr, ext_buffer_addr;
  logic [39:0] ext_buffer_data;
  logic [31:0] ext_pending_ints;
  logic [5:0]  ext_out_reg_addr;
  logic [31:0] ext_out_reg_data, ext_out_stbs, ext_clear_ints;
  logic        ext_out_reg_stb, complete, busy, waiting;
  logic [15:0] pc;
  logic [7:0]  error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] cyc      = 32'd0;
  ev_t         exp_q[$];
  logic        done_pending = 1'b0;
  logic [31:0] done_cyc     = 32'd0;
  logic [31:0] n0;
  logic        stall_ok;

  buf_executor_seq dut (
    .clk(clk), .rst(rst),
    .ext_out_reg_addr(ext_out_reg_addr), .ext_out_reg_data(ext_out_reg_data),
    .ext_out_reg_stb(ext_out_reg_stb), .ext_out_reg_busy(ext_out_reg_busy),
    .ext_out_stbs(ext_out_stbs), .ext_pending_ints(ext_pending_ints),
    .ext_clear_ints(ext_clear_ints), .ext_buffer_addr(ext_buffer_addr),
    .ext_buffer_data(ext_buffer_data), .ext_buffer_wr(ext_buffer_wr),
    .start(start), .start_addr(start_addr), .abort(abort), .complete(complete),
    .pc(pc), .error(error), .busy(busy), .waiting(waiting)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic logic [39:0] i_wr(logic [5:0] a, logic [31:0] d);
    return {2'b01, a, d};
  endfunction

  function automatic logic [39:0] i_misc(logic [5:0] s, logic [31:0] a);
    return {2'b10, s, a};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(logic [1:0] k, logic [39:0] v, logic [31:0] c);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic take(logic [1:0] k, logic [39:0] v, logic [31:0] c);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_unexpected: got kind=%0d val=%0h cyc=%0d expected no event", k, v, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.val !== v || (e.cyc != NOCYC && e.cyc != c)) begin
        n_fail++;
        $display("FAIL scoreboard: got kind=%0d val=%0h cyc=%0d expected kind=%0d val=%0h cyc=%0d",
                 k, v, c, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every DUT output event is matched against the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (ext_out_reg_stb)      take(K_REG, {2'b00, ext_out_reg_addr, ext_out_reg_data}, cyc);
      if (ext_out_stbs != 0)    take(K_STB, {8'h00, ext_out_stbs}, cyc);
      if (ext_clear_ints != 0)  take(K_CLR, {8'h00, ext_clear_ints}, cyc);
      if (complete) begin
        done_pending = 1'b1;
        done_cyc     = cyc;
      end else if (done_pending) begin
        done_pending = 1'b0;
        take(K_DONE, {31'h0, error, busy}, done_cyc);
      end
    end
  end

  task automatic load(logic [15:0] a, logic [39:0] d);
    @(negedge clk);
    ext_buffer_addr = a; ext_buffer_data = d; ext_buffer_wr = 1'b1;
    @(posedge clk);
    #1 ext_buffer_wr = 1'b0;
  endtask

  task automatic pulse_start(logic [15:0] a);
    start = 1'b1; start_addr = a;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_prog(string name);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (busy && i < 500);
    check({name, "_idle"}, busy, 1'b0);
    @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_waiting(string name);
    int i;
    i = 0;
    while (!waiting && i < 100) begin
      @(negedge clk);
      i++;
    end
    check({name, "_waiting"}, waiting, 1'b1);
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; start = 1'b0; start_addr = 16'h0;
    ext_out_reg_busy = 1'b0; ext_buffer_wr = 1'b0; ext_buffer_addr = 16'h0;
    ext_buffer_data = 40'h0; ext_pending_ints = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_state", {pc, error, busy, waiting, complete, ext_out_reg_stb}, 64'h0);
    check("reset_comb_vectors", {ext_out_stbs, ext_clear_ints}, 64'h0);
    rst = 1'b0;

    load(16'h0000, i_wr(6'd5, 32'h1234));
    load(16'h0001, i_misc(6'd1, 32'h3));
    load(16'h0002, i_misc(6'd63, 32'h0));
    load(16'h0010, i_misc(6'd5, 32'd3));
    load(16'h0011, i_misc(6'd4, 32'h1));
    load(16'h0012, i_misc(6'd6, 32'h0));
    load(16'h0013, i_misc(6'd63, 32'h0));
    load(16'h0020, i_misc(6'd5, 32'd0));
    load(16'h0021, i_misc(6'd4, 32'h1));
    load(16'h0022, i_misc(6'd6, 32'h0));
    load(16'h0023, i_misc(6'd63, 32'h0));
    load(16'h0030, i_misc(6'd8, 32'd4));
    load(16'h0031, i_misc(6'd2, 32'h6));
    load(16'h0032, i_misc(6'd63, 32'h0));
    load(16'h0040, i_misc(6'd8, 32'd1));
    load(16'h0041, i_wr(6'd7, 32'hABCD));
    load(16'h0042, i_misc(6'd63, 32'h0));
    load(16'h0050, 40'h00_0000_0000);
    load(16'h0058, i_misc(6'd9, 32'h0));
    load(16'h0060, i_misc(6'd5, 32'd2));
    load(16'h0061, i_misc(6'd5, 32'd2));
    load(16'h0070, i_misc(6'd6, 32'h0));
    load(16'h0080, i_misc(6'd7, 32'hFFFF));
    load(16'h1FFF, i_misc(6'd0, 32'h0));
    load(16'h0090, i_misc(6'd3, 32'h100));

    // Basic program with exact cycle positions.
    @(negedge clk); n0 = cyc + 32'd1;
    push(K_REG, {2'b00, 6'd5, 32'h1234}, n0 + 32'd1);
    push(K_STB, 40'h3, n0 + 32'd3);
    push(K_DONE, {31'h0, 8'h00, 1'b0}, n0 + 32'd5);
    pulse_start(16'h0000);
    check("busy_after_start", busy, 1'b1);
    finish_prog("basic");

    @(negedge clk);
    push(K_CLR, 40'h1, NOCYC); push(K_CLR, 40'h1, NOCYC); push(K_CLR, 40'h1, NOCYC);
    push(K_DONE, {31'h0, 8'h00, 1'b0}, NOCYC);
    pulse_start(16'h0010);
    finish_prog("loop3");

    @(negedge clk);
    push(K_CLR, 40'h1, NOCYC);
    push(K_DONE, {31'h0, 8'h00, 1'b0}, NOCYC);
    pulse_start(16'h0020);
    finish_prog("loop0");

    // Timeout of 4 expires on the 4th failed check.
    @(negedge clk); n0 = cyc + 32'd1; ext_pending_ints = 32'h2;
    push(K_DONE, {31'h0, 8'h83, 1'b0}, n0 + 32'd6);
    pulse_start(16'h0030);
    while (cyc < n0 + 32'd4) @(negedge clk);
    check("wait_flag", waiting, 1'b1);
    check("wait_error", error, 8'h02);
    finish_prog("timeout");
    check("timeout_waiting_cleared", waiting, 1'b0);

    // Condition met exactly on the 4th check wins over the timeout.
    @(negedge clk); n0 = cyc + 32'd1; ext_pending_ints = 32'h2;
    push(K_DONE, {31'h0, 8'h00, 1'b0}, n0 + 32'd8);
    pulse_start(16'h0030);
    while (cyc < n0 + 32'd6) @(negedge clk);
    ext_pending_ints = 32'h6;
    finish_prog("timeout_met");
    ext_pending_ints = 32'h0;

    // WRITE_REG stall: busy for 10 decode cycles, timeout 1, stray start ignored.
    @(negedge clk); n0 = cyc + 32'd1; ext_out_reg_busy = 1'b1;
    push(K_REG, {2'b00, 6'd7, 32'hABCD}, n0 + 32'd13);
    push(K_DONE, {31'h0, 8'h00, 1'b0}, n0 + 32'd15);
    pulse_start(16'h0040);
    while (cyc < n0 + 32'd3) @(negedge clk);
    stall_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (ext_out_reg_stb || pc != 16'h0041 || !busy) stall_ok = 1'b0;
      start = (i == 4); start_addr = 16'h0030;
      if (i < 9) @(negedge clk);
    end
    @(posedge clk);
    #1 ext_out_reg_busy = 1'b0; start = 1'b0;
    check("stall_held", stall_ok, 1'b1);
    finish_prog("stall");

    @(negedge clk);
    push(K_DONE, {31'h0, 8'h81, 1'b0}, NOCYC);
    pulse_start(16'h0050);
    finish_prog("op00");

    @(negedge clk);
    push(K_DONE, {31'h0, 8'h81, 1'b0}, NOCYC);
    pulse_start(16'h0058);
    finish_prog("bad_sub");

    @(negedge clk);
    push(K_DONE, {31'h0, 8'h84, 1'b0}, NOCYC);
    pulse_start(16'h0060);
    finish_prog("nested");

    @(negedge clk);
    push(K_DONE, {31'h0, 8'h85, 1'b0}, NOCYC);
    pulse_start(16'h0070);
    finish_prog("stray_end");

    // JUMP to 0xFFFF: NOP at the last buffer word, then pc wraps to 0.
    load(16'h0000, i_misc(6'd63, 32'h11));
    @(negedge clk);
    push(K_DONE, {31'h0, 8'h11, 1'b0}, NOCYC);
    pulse_start(16'h0080);
    finish_prog("wrap");
    check("wrap_pc", pc, 16'h0000);

    // Abort while waiting.
    @(negedge clk); ext_pending_ints = 32'h0;
    pulse_start(16'h0090);
    wait_waiting("abort");
    @(negedge clk);
    abort = 1'b1;
    #1 check("abort_no_complete", complete, 1'b0);
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_state", {pc, error, busy, waiting}, {16'h0000, 8'h82, 1'b0, 1'b0});
    @(negedge clk);
    check("abort_queue_empty", exp_q.size(), 0);

    // Reset dominates a simultaneous abort.
    @(negedge clk);
    pulse_start(16'h0090);
    wait_waiting("rst_abort");
    @(negedge clk);
    rst = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; abort = 1'b0;
    check("rst_abort_state", {pc, error, busy, waiting}, {16'h0000, 8'h00, 1'b0, 1'b0});

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
